// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing a single-port, registered-read
//               memory between two requesters over a req/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          done0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          done1,
    output logic [DW-1:0] rdata1,
    output logic          busy,
    output logic          owner,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_val,
    output logic          mem_get,
    output logic          mem_set,
    input  logic [DW-1:0] mem_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_val_q, mem_val_d;
    logic          mem_get_q, mem_get_d;
    logic          mem_set_q, mem_set_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          busy_q, busy_d;
    logic          pick1;

    // ptr_q = 1 favours requester 1 on a tie; a grant always hands the tie to the other side
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        we_d       = we_q;
        mem_addr_d = mem_addr_q;
        mem_val_d  = mem_val_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        busy_d     = busy_q;
        mem_get_d  = 1'b0;
        mem_set_d  = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        pick1      = req1 && (!req0 || ptr_q);

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d    = pick1;
                    ptr_d      = !pick1;
                    we_d       = pick1 ? we1 : we0;
                    mem_addr_d = pick1 ? addr1 : addr0;
                    mem_val_d  = pick1 ? wdata1 : wdata0;
                    mem_set_d  = we_d;
                    mem_get_d  = !we_d;
                    busy_d     = 1'b1;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    done0_d = !owner_q;
                    done1_d = owner_q;
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (owner_q) begin
                    rdata1_d = mem_out;
                end else begin
                    rdata0_d = mem_out;
                end
                done0_d = !owner_q;
                done1_d = owner_q;
                state_d = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            mem_addr_q <= '0;
            mem_val_q  <= '0;
            mem_get_q  <= 1'b0;
            mem_set_q  <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            mem_addr_q <= mem_addr_d;
            mem_val_q  <= mem_val_d;
            mem_get_q  <= mem_get_d;
            mem_set_q  <= mem_set_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            busy_q     <= busy_d;
        end
    end

    assign done0    = done0_q;
    assign done1    = done1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign busy     = busy_q;
    assign owner    = owner_q;
    assign mem_addr = mem_addr_q;
    assign mem_val  = mem_val_q;
    assign mem_get  = mem_get_q;
    assign mem_set  = mem_set_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a transaction-level
//               reference model and a behavioural 256x8 memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [3:0] dly;
    } txn_t;

    logic       clk;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       done0, done1;
    logic [7:0] rdata0, rdata1;
    logic       busy, owner;
    logic [7:0] mem_addr, mem_val, mem_out;
    logic       mem_get, mem_set;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] mem     [256] = '{default: 8'h00};
    logic [7:0] ref_mem [256] = '{default: 8'h00};
    logic       prev_busy = 1'b0;

    // Reference model state: one active transaction at a time
    txn_t       q0[$], q1[$];
    int         dut_grants[$];
    logic       ptr       = 1'b0;
    logic       act_valid = 1'b0;
    logic       act_owner = 1'b0;
    logic       act_we    = 1'b0;
    logic [7:0] act_addr  = 8'h00;
    logic [7:0] act_wdata = 8'h00;
    logic [7:0] act_rd    = 8'h00;
    logic       exp_owner = 1'b0;
    logic [7:0] hold [2]  = '{8'h00, 8'h00};
    int         g_t = -10, d_t = -10, idle_at = 0;
    logic       armed0 = 1'b0, armed1 = 1'b0;
    int         wc0 = 0, wc1 = 0;

    mem_arbiter #(.AW(8), .DW(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .done0(done0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .done1(done1), .rdata1(rdata1),
        .busy(busy), .owner(owner),
        .mem_addr(mem_addr), .mem_val(mem_val),
        .mem_get(mem_get), .mem_set(mem_set), .mem_out(mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // System memory: registered read, write wins over read
    initial mem_out = 8'h00;
    always @(posedge clk) begin
        if (mem_set) mem[mem_addr] <= mem_val;
        else if (mem_get) mem_out <= mem[mem_addr];
    end

    // Strobes: mutually exclusive and only in the first busy cycle after idle
    always @(negedge clk) begin
        checks++;
        assert ((mem_get && mem_set) === 1'b0) else begin
            errors++;
            $error("FAIL strobe_excl: observed get=%0b set=%0b required not both", mem_get, mem_set);
        end
        if (mem_get || mem_set) begin
            checks++;
            assert ((busy && !prev_busy) === 1'b1) else begin
                errors++;
                $error("FAIL strobe_state: observed busy=%0b prev_busy=%0b required 1/0", busy, prev_busy);
            end
        end
        prev_busy = busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s @cyc %0d: observed %0h required %0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic txn_t mk(input logic we, input logic [7:0] a, input logic [7:0] d,
                                input logic [3:0] dly);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d; t.dly = dly;
        return t;
    endfunction

    // Runs queued transactions to completion, checking every cycle.
    // Write: done at grant+2, next idle grant+3. Read: done grant+3, idle grant+4.
    task automatic run(input int max_cyc);
        int   budget;
        logic r0, r1;
        txn_t f;
        budget = max_cyc;
        forever begin
            if (act_valid && cyc == g_t + 1) begin
                exp_owner = act_owner;
                dut_grants.push_back(int'(owner));
                chk("mem_addr", 32'(mem_addr), 32'(act_addr));
                if (act_we) chk("mem_val", 32'(mem_val), 32'(act_wdata));
            end
            chk("busy", 32'(busy), 32'(act_valid && cyc > g_t && cyc <= d_t));
            chk("owner", 32'(owner), 32'(exp_owner));
            chk("mem_set", 32'(mem_set), 32'(act_valid && cyc == g_t + 1 && act_we));
            chk("mem_get", 32'(mem_get), 32'(act_valid && cyc == g_t + 1 && !act_we));
            if (act_valid && cyc == d_t && !act_we) hold[act_owner] = act_rd;
            chk("done0", 32'(done0), 32'(act_valid && cyc == d_t && act_owner == 1'b0));
            chk("done1", 32'(done1), 32'(act_valid && cyc == d_t && act_owner == 1'b1));
            chk("rdata0", 32'(rdata0), 32'(hold[0]));
            chk("rdata1", 32'(rdata1), 32'(hold[1]));
            if (act_valid && cyc == d_t) begin
                if (act_owner) begin void'(q1.pop_front()); armed1 = 1'b0; end
                else begin void'(q0.pop_front()); armed0 = 1'b0; end
                act_valid = 1'b0;
                idle_at   = cyc + 1;
            end

            if (!armed0 && q0.size() > 0) begin armed0 = 1'b1; wc0 = int'(q0[0].dly); end
            if (!armed1 && q1.size() > 0) begin armed1 = 1'b1; wc1 = int'(q1[0].dly); end
            if (armed0 && wc0 > 0) begin wc0--; r0 = 1'b0; end else r0 = armed0;
            if (armed1 && wc1 > 0) begin wc1--; r1 = 1'b0; end else r1 = armed1;
            req0 = r0; req1 = r1;
            if (armed0) begin we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].wdata; end
            else begin we0 = 1'($urandom); addr0 = 8'($urandom); wdata0 = 8'($urandom); end
            if (armed1) begin we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].wdata; end
            else begin we1 = 1'($urandom); addr1 = 8'($urandom); wdata1 = 8'($urandom); end

            if (!act_valid && cyc >= idle_at && (r0 || r1)) begin
                act_owner = (r0 && r1) ? ptr : r1;
                ptr       = !act_owner;
                f         = act_owner ? q1[0] : q0[0];
                act_we    = f.we;
                act_addr  = f.addr;
                act_wdata = f.wdata;
                g_t       = cyc;
                d_t       = cyc + (f.we ? 2 : 3);
                if (f.we) ref_mem[f.addr] = f.wdata;
                else act_rd = ref_mem[f.addr];
                act_valid = 1'b1;
            end

            if (!act_valid && cyc >= idle_at && q0.size() == 0 && q1.size() == 0) break;
            if (budget == 0) begin
                checks++; errors++;
                $error("FAIL run_timeout @cyc %0d: observed still active required completion", cyc);
                break;
            end
            budget--;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        chk("rst_done0", 32'(done0), 32'd0);
        chk("rst_done1", 32'(done1), 32'd0);
        chk("rst_get", 32'(mem_get), 32'd0);
        chk("rst_set", 32'(mem_set), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_rdata0", 32'(rdata0), 32'd0);
        chk("rst_rdata1", 32'(rdata1), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_val", 32'(mem_val), 32'd0);
        idle_at = cyc;

        // Single write from requester 0, then a read of it from requester 1
        q0.push_back(mk(1'b1, 8'h10, 8'h5A, 4'd0));
        run(50);
        q1.push_back(mk(1'b0, 8'h10, 8'h00, 4'd0));
        run(50);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rdata1_hold", 32'(rdata1), 32'h5A);
            chk("done1_quiet", 32'(done1), 32'd0);
        end

        // Preload, then both requesters stream four reads each
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'b1, 8'(8'h40 + i), 8'($urandom), 4'd0));
            q1.push_back(mk(1'b1, 8'(8'h44 + i), 8'($urandom), 4'd0));
        end
        run(200);
        dut_grants.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'b0, 8'(8'h40 + i), 8'h00, 4'd0));
            q1.push_back(mk(1'b0, 8'(8'h44 + i), 8'h00, 4'd0));
        end
        run(200);
        chk("grant_count", 32'(dut_grants.size()), 32'd8);
        for (int i = 0; i < dut_grants.size(); i++) chk("grant_order", 32'(dut_grants[i]), 32'(i % 2));

        // Requester 1 alone three times, then both contend: 0 must win
        for (int i = 0; i < 3; i++)
            q1.push_back(mk(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), 4'd0));
        run(100);
        dut_grants.delete();
        q0.push_back(mk(1'b0, 8'h44, 8'h00, 4'd0));
        q1.push_back(mk(1'b0, 8'h41, 8'h00, 4'd0));
        run(100);
        chk("contend_first", 32'(dut_grants[0]), 32'd0);
        chk("contend_second", 32'(dut_grants[1]), 32'd1);

        // Reset during the ACCESS cycle of a write
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 8'hC3;
        tick();
        chk("acc_set", 32'(mem_set), 32'd1);
        chk("acc_addr", 32'(mem_addr), 32'h20);
        chk("acc_val", 32'(mem_val), 32'hC3);
        rst = 1'b1;
        req0 = 1'b0;
        tick();
        rst = 1'b0;
        chk("rr_done0", 32'(done0), 32'd0);
        chk("rr_done1", 32'(done1), 32'd0);
        chk("rr_get", 32'(mem_get), 32'd0);
        chk("rr_set", 32'(mem_set), 32'd0);
        chk("rr_busy", 32'(busy), 32'd0);
        chk("rr_owner", 32'(owner), 32'd0);
        chk("rr_rdata0", 32'(rdata0), 32'd0);
        chk("rr_rdata1", 32'(rdata1), 32'd0);
        chk("rr_addr", 32'(mem_addr), 32'd0);
        chk("rr_val", 32'(mem_val), 32'd0);
        ref_mem[8'h20] = 8'hC3;
        ptr = 1'b0; exp_owner = 1'b0; hold[0] = 8'h00; hold[1] = 8'h00;
        act_valid = 1'b0; idle_at = cyc;
        q0.push_back(mk(1'b0, 8'h20, 8'h00, 4'd0));
        run(50);
        chk("post_rst_read", 32'(hold[0]), 32'hC3);

        // Randomized traffic with address collisions and request gaps
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0)
                q0.push_back(mk(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
                                4'($urandom_range(0, 3))));
            else
                q1.push_back(mk(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
                                4'($urandom_range(0, 3))));
        end
        run(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
